// File: rtl/mem_wb_pipe_stage.sv
// MEM/WB elastic pipeline stage: valid/ready handshake, synchronous flush and write-back mux.
// Define PIPE_SKID_EN for the EMPTY/FULL/SKID variant with a second (skid) entry register.
module mem_wb_pipe_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] memdata_i,
   input  logic [DATA_W-1:0] alures_i,
   input  logic [DATA_W-1:0] pc4_i,
   input  logic [1:0]        memtoreg_i,
   input  logic              regwr_i,
   input  logic [REG_W-1:0]  rf_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] memdata_o,
   output logic [DATA_W-1:0] alures_o,
   output logic [DATA_W-1:0] pc4_o,
   output logic [1:0]        memtoreg_o,
   output logic              regwr_o,
   output logic [REG_W-1:0]  rf_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              wb_we_o
);
   localparam int ENT_W = 3*DATA_W + 3 + REG_W;
   localparam int RWR_B = REG_W;

   logic [ENT_W-1:0] in_ent_s;
   logic [ENT_W-1:0] main_q;
   logic             out_valid_q;

   assign in_ent_s  = {memdata_i, alures_i, pc4_i, memtoreg_i, regwr_i, rf_i};
   assign {memdata_o, alures_o, pc4_o, memtoreg_o, regwr_o, rf_o} = main_q;
   assign out_valid = out_valid_q;

`ifdef PIPE_SKID_EN
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   state_e           state_q;
   logic [ENT_W-1:0] skid_q;
   logic             in_ready_q;

   // in_ready comes from a flop, so out_ready never reaches it combinationally
   assign in_ready = in_ready_q;

   // Skid FSM: state, handshake flags, main and skid entries.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_q      <= {ENT_W{1'b0}};
         skid_q      <= {ENT_W{1'b0}};
      end else if (flush) begin
         state_q       <= ST_EMPTY;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         main_q[RWR_B] <= 1'b0;
         skid_q[RWR_B] <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_valid) begin
                  main_q      <= in_ent_s;
                  state_q     <= ST_FULL;
                  out_valid_q <= 1'b1;
               end else begin
                  state_q     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (in_valid && out_ready) begin
                  main_q      <= in_ent_s;
               end else if (in_valid) begin
                  skid_q      <= in_ent_s;
                  state_q     <= ST_SKID;
                  in_ready_q  <= 1'b0;
               end else if (out_ready) begin
                  state_q     <= ST_EMPTY;
                  out_valid_q <= 1'b0;
               end else begin
                  state_q     <= ST_FULL;
               end
            end
            ST_SKID: begin
               if (out_ready) begin
                  main_q      <= skid_q;
                  state_q     <= ST_FULL;
                  in_ready_q  <= 1'b1;
               end else begin
                  state_q     <= ST_SKID;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end
`else
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   state_e state_q;
   logic   accept_s;
   logic   drain_s;

   assign in_ready = ~out_valid_q | out_ready;
   assign accept_s = in_valid & in_ready;
   assign drain_s  = out_valid_q & out_ready;

   // Single-register FSM: state, valid flag and main entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         main_q      <= {ENT_W{1'b0}};
      end else if (flush) begin
         state_q       <= ST_EMPTY;
         out_valid_q   <= 1'b0;
         main_q[RWR_B] <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_s) begin
                  main_q      <= in_ent_s;
                  state_q     <= ST_FULL;
                  out_valid_q <= 1'b1;
               end else begin
                  state_q     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (accept_s) begin
                  main_q      <= in_ent_s;
               end else if (drain_s) begin
                  state_q     <= ST_EMPTY;
                  out_valid_q <= 1'b0;
               end else begin
                  state_q     <= ST_FULL;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end
`endif

   // Write-back select; code 2'b11 forces zero.
   always_comb begin
      wb_data_o = {DATA_W{1'b0}};
      case (memtoreg_o)
         2'b00:   wb_data_o = alures_o;
         2'b01:   wb_data_o = memdata_o;
         2'b10:   wb_data_o = pc4_o;
         default: wb_data_o = {DATA_W{1'b0}};
      endcase
   end

   assign wb_we_o = out_valid_q & regwr_o & (rf_o != {REG_W{1'b0}});

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: vector table driven through a queue scoreboard plus
// hand sequences for back-pressure, flush and reset; follows PIPE_SKID_EN if defined.
module tb_mem_wb_pipe_stage;
   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] memdata_i, alures_i, pc4_i, memdata_o, alures_o, pc4_o, wb_data_o;
   logic [1:0]  memtoreg_i, memtoreg_o;
   logic        regwr_i, regwr_o, wb_we_o;
   logic [4:0]  rf_i, rf_o;

   always #5 clk = ~clk;

   mem_wb_pipe_stage #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .memdata_i(memdata_i), .alures_i(alures_i), .pc4_i(pc4_i),
      .memtoreg_i(memtoreg_i), .regwr_i(regwr_i), .rf_i(rf_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .memdata_o(memdata_o), .alures_o(alures_o), .pc4_o(pc4_o),
      .memtoreg_o(memtoreg_o), .regwr_o(regwr_o), .rf_o(rf_o),
      .wb_data_o(wb_data_o), .wb_we_o(wb_we_o)
   );

   typedef struct packed {
      logic [31:0] memdata;
      logic [31:0] alures;
      logic [31:0] pc4;
      logic [1:0]  m2r;
      logic        regwr;
      logic [4:0]  rf;
      logic [31:0] wb;
      logic        we;
   } vec_t;

   vec_t vecs [21];
   vec_t sb_q [$];
   vec_t cur_v;
   vec_t s_v;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;
   bit   seen99 = 1'b0;
   logic s_acc = 1'b0, s_drain = 1'b0, s_rst_n = 1'b0, s_flush = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every cycle: compare outputs against the scoreboard head and the expected handshake.
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
`ifdef PIPE_SKID_EN
         check("in_ready", 32'(in_ready), 32'(sb_q.size() < 2));
`else
         check("in_ready", 32'(in_ready), 32'((sb_q.size() == 0) || out_ready));
`endif
         if (sb_q.size() != 0) begin
            check("wb_data_o", wb_data_o, sb_q[0].wb);
            check("wb_we_o", 32'(wb_we_o), 32'(sb_q[0].we));
            check("alures_o", alures_o, sb_q[0].alures);
            check("memdata_o", memdata_o, sb_q[0].memdata);
            check("pc4_o", pc4_o, sb_q[0].pc4);
            check("memtoreg_o", 32'(memtoreg_o), 32'(sb_q[0].m2r));
            check("regwr_o", 32'(regwr_o), 32'(sb_q[0].regwr));
            check("rf_o", 32'(rf_o), 32'(sb_q[0].rf));
         end else begin
            check("wb_we_idle", 32'(wb_we_o), 32'd0);
         end
         if (out_valid && alures_o == 32'h99) seen99 = 1'b1;
      end
      s_acc   = in_valid & in_ready;
      s_drain = out_valid & out_ready;
      s_rst_n = reset;
      s_flush = flush;
      s_v     = cur_v;
   end

   // Scoreboard update on the edge the handshake takes effect.
   always @(posedge clk) begin
      if (!s_rst_n || s_flush) begin
         sb_q.delete();
      end else begin
         if (s_drain && sb_q.size() != 0) void'(sb_q.pop_front());
         if (s_acc) sb_q.push_back(s_v);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_vec(input vec_t v, input logic vld);
      memdata_i  = v.memdata;
      alures_i   = v.alures;
      pc4_i      = v.pc4;
      memtoreg_i = v.m2r;
      regwr_i    = v.regwr;
      rf_i       = v.rf;
      in_valid   = vld;
      cur_v      = v;
   endtask

   // Present vecs[first..first+n-1] in order; out_ready follows pat bit per cycle.
   task automatic run_seq(input int first, input int n, input logic [15:0] pat);
      int idx = 0;
      int c   = 0;
      while (idx < n && c < 40) begin
         drive_vec(vecs[first+idx], 1'b1);
         out_ready = (c < 16) ? pat[c] : 1'b1;
         @(negedge clk);
         if (in_ready === 1'b1) idx++;
         step();
         c++;
      end
      in_valid = 1'b0;
      check("run_seq_accepted", 32'(idx), 32'(n));
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_memdata"}, memdata_o, 32'd0);
      check({tag, "_alures"}, alures_o, 32'd0);
      check({tag, "_pc4"}, pc4_o, 32'd0);
      check({tag, "_memtoreg"}, 32'(memtoreg_o), 32'd0);
      check({tag, "_regwr"}, 32'(regwr_o), 32'd0);
      check({tag, "_rf"}, 32'(rf_o), 32'd0);
      check({tag, "_wb_data"}, wb_data_o, 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_wb_we"}, 32'(wb_we_o), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         vecs[i] = '{memdata: 32'hA000_0000 + 32'(i), alures: 32'h10 + 32'(i),
                     pc4: 32'h0040_0000 + 32'(4*i), m2r: 2'b00, regwr: 1'b1, rf: 5'd8,
                     wb: 32'h10 + 32'(i), we: 1'b1};
      end
      vecs[8]  = '{32'hDEADBEEF, 32'h1, 32'h2, 2'b01, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1};
      vecs[9]  = '{32'h5, 32'h6, 32'h0040_0004, 2'b10, 1'b1, 5'd31, 32'h0040_0004, 1'b1};
      vecs[10] = '{32'h7, 32'h77, 32'h8, 2'b00, 1'b1, 5'd0, 32'h77, 1'b0};
      vecs[11] = '{32'h9, 32'h55, 32'hA, 2'b11, 1'b1, 5'd4, 32'h0, 1'b1};
      vecs[12] = '{32'hB, 32'h66, 32'hC, 2'b00, 1'b0, 5'd9, 32'h66, 1'b0};
      vecs[13] = '{32'h0, 32'hA, 32'h0, 2'b00, 1'b1, 5'd10, 32'hA, 1'b1};
      vecs[14] = '{32'h0, 32'hB, 32'h0, 2'b00, 1'b1, 5'd10, 32'hB, 1'b1};
      vecs[15] = '{32'h0, 32'hC, 32'h0, 2'b00, 1'b1, 5'd10, 32'hC, 1'b1};
      vecs[16] = '{32'h0, 32'hF1, 32'h0, 2'b00, 1'b1, 5'd11, 32'hF1, 1'b1};
      vecs[17] = '{32'h0, 32'hF2, 32'h0, 2'b00, 1'b1, 5'd11, 32'hF2, 1'b1};
      vecs[18] = '{32'h0, 32'h99, 32'h0, 2'b00, 1'b1, 5'd12, 32'h99, 1'b1};
      vecs[19] = '{32'h0, 32'hE1, 32'h0, 2'b01, 1'b1, 5'd13, 32'h0, 1'b1};
      vecs[20] = '{32'h0, 32'hE2, 32'h0, 2'b10, 1'b1, 5'd14, 32'h0, 1'b1};

      // Reset held two cycles while MEM presents an entry.
      reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
      cur_v = '0;
      drive_vec(cur_v, 1'b1);
      alures_i = 32'h1234;
      step();
      chk_en = 1'b1;
      step();
      @(negedge clk);
      check_zero_outputs("reset");
      step();
      reset = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("reset_release_in_ready", 32'(in_ready), 32'd1);
      step();

      // Streaming and write-back mux vectors at full throughput.
      run_seq(0, 13, 16'hFFFF);
      out_ready = 1'b1;
      repeat (3) step();

      // Back-pressure: A, then out_ready low for three cycles.
      run_seq(13, 3, 16'hFFF1);
      out_ready = 1'b1;
      repeat (4) step();

      // Flush with two entries held and a new entry presented.
      run_seq(16, 2, 16'hFFFD);
      out_ready = 1'b0;
      flush = 1'b1;
      drive_vec(vecs[18], 1'b1);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_wb_we", 32'(wb_we_o), 32'd0);
      step();
      out_ready = 1'b1;
      repeat (3) step();

      // Flush from FULL: the same-cycle entry is accepted and discarded.
      run_seq(16, 1, 16'hFFFF);
      flush = 1'b1;
      drive_vec(vecs[18], 1'b1);
      out_ready = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush2_out_valid", 32'(out_valid), 32'd0);
      step();
      repeat (2) step();

      // Reset with two entries held.
      run_seq(19, 2, 16'hFFFD);
      out_ready = 1'b0;
      reset = 1'b0;
      step();
      @(negedge clk);
      check_zero_outputs("midreset");
      step();
      reset = 1'b1;
      @(negedge clk);
      check("midreset_in_ready", 32'(in_ready), 32'd1);
      step();

      out_ready = 1'b1;
      repeat (3) step();
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      check("flushed_0x99_never_seen", 32'(seen99), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_wb_pipe_stage.md
# mem_wb_pipe_stage

Parametrised, elastic MEM/WB pipeline stage for the MIPS pipeline. It carries the memory read data, ALU result, link address, write-back select, register-write enable and destination register from MEM to WB. It adds a valid/ready handshake, a synchronous flush and a write-back result mux. An optional two-entry skid buffer keeps full throughput when WB back-pressures.

## Interface
- DATA_W, 32, width of the data paths (memdata, alures, pc4, wb_data)
- REG_W, 5, width of the destination register index
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  MEM presents a valid entry
- in_ready  out  1  stage accepts an entry this cycle
- memdata_i  in  DATA_W  data-memory read data
- alures_i  in  DATA_W  ALU result
- pc4_i  in  DATA_W  link address (PC+4)
- memtoreg_i  in  2  write-back select
- regwr_i  in  1  register-write enable
- rf_i  in  REG_W  destination register index
- out_valid  out  1  WB entry valid
- out_ready  in  1  WB consumes the entry this cycle
- memdata_o, alures_o, pc4_o  out  DATA_W  registered copies of the inputs
- memtoreg_o  out  2; regwr_o  out  1; rf_o  out  REG_W  registered copies of the inputs
- wb_data_o  out  DATA_W  selected write-back value
- wb_we_o  out  1  register-file write strobe

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Entry = {memdata, alures, pc4, memtoreg, regwr, rf}. Entries leave in arrival order; none is lost or duplicated.
- wb_data_o is combinational from the main entry:
  - memtoreg 00 -> alures_o
  - memtoreg 01 -> memdata_o
  - memtoreg 10 -> pc4_o
  - memtoreg 11 -> all zeros
- wb_we_o = out_valid & regwr_o & (rf_o != 0). Writes to $0 are suppressed.
- State machine (PIPE_SKID_EN defined), with a main register and a skid register:
  - EMPTY: in_ready=1, out_valid=0. in_valid -> load main, go to FULL.
  - FULL: in_ready=1, out_valid=1.
    - in_valid & out_ready -> load main with the input, stay FULL.
    - in_valid & ~out_ready -> load skid, go to SKID.
    - ~in_valid & out_ready -> go to EMPTY.
    - Neither -> hold.
  - SKID: in_ready=0, out_valid=1. out_ready -> main <= skid, go to FULL. Otherwise hold.
- in_ready is decoded from state only, so there is no combinational path from out_ready to in_ready.
- Flush: next state is EMPTY and both valids clear. An entry presented in the same cycle is accepted by the handshake (in_ready as decoded) and discarded. Payload registers keep their values; regwr_o is cleared.
- Priority: reset > flush > handshake.

## Timing
- Reset: on a rising edge with reset=0, state goes to EMPTY.
  - All payload outputs become 0, out_valid=0, wb_we_o=0, wb_data_o=0.
  - in_ready=1 from the first edge after that.
- Latency: an entry accepted at edge N is on the outputs with out_valid=1 after edge N, so WB sees it in cycle N+1.
- Throughput: 1 entry per cycle while out_ready=1.
- Back-pressure: an out_ready drop costs at most one skid slot. in_ready falls the cycle after the skid fills.
- Reset or flush mid-SKID: both entries are discarded. in_ready=1 the next cycle.
- out_ready without out_valid is ignored.

## Configuration
- PIPE_SKID_EN defined: three-state EMPTY/FULL/SKID machine with the skid register, as above.
- PIPE_SKID_EN undefined: single register, two states EMPTY/FULL, no skid storage.
  - in_ready = ~out_valid | out_ready (combinational).
  - Same latency, same flush and reset behaviour.

## Test plan
- Reset/idle: hold reset=0 for 2 cycles with in_valid=1, alures_i=0x1234 -> all outputs 0, out_valid=0. After release, in_ready=1.
- Streaming: 8 back-to-back entries, alures_i=0x10..0x17, memtoreg=00, regwr=1, rf=8, out_ready=1 -> wb_data_o equals 0x10..0x17 one cycle after each input, in order, with wb_we_o=1 each cycle.
- Mux/$0 case:
  - memtoreg=01, memdata=0xDEADBEEF -> wb_data_o=0xDEADBEEF.
  - memtoreg=10, pc4=0x400004 -> wb_data_o=0x400004.
  - rf=0 with regwr=1 -> wb_we_o=0.
- Back-pressure: stream A, B, C, drop out_ready for 3 cycles, then raise it -> with PIPE_SKID_EN, in_ready=0 while two entries are held and output order is A, B, C with no drops. Without the macro, in_ready tracks out_ready and the order is unchanged.
- Flush: fill to SKID, then pulse flush together with in_valid=1 (alures=0x99) -> next cycle out_valid=0 and wb_we_o=0, and 0x99 never appears.
- Reset mid-operation: reset=0 while in SKID -> next cycle outputs are 0, state is EMPTY, in_ready=1 after release.
